amoa_param_pipe: RTL

AMOA_PARAM_PIPE -- requirements
Module: amoa_param_pipe

---
 rtl/amoa_pkg.sv | 32 +++
 rtl/amoa_cprs42_apx.sv | 37 +++
 rtl/amoa_param_pipe.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/amoa_pkg.sv
// Shared definitions for the approximate multi-operand adder pipeline:
// width helpers and the payload carried between pipeline stages.
package amoa_pkg;

  // Widest output: W=32 operands, N=16 -> 32 + 4 + 1.
  localparam int MAX_OW = 37;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < v) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

  function automatic int ow_of(input int w, input int n);
    return w + clog2(n) + 1;
  endfunction

  // Tree-to-CPA payload; err holds the per-column err bits already weighted
  // at column c+1, i.e. exactly the amount the approximate cells dropped.
  typedef struct packed {
    logic              valid;
    logic [MAX_OW-1:0] psum;
    logic [MAX_OW-1:0] pcar;
    logic [MAX_OW-1:0] err;
  } stage_t;

endpackage

// File: rtl/amoa_cprs42_apx.sv
// 4:2 compressor cell: carry-free approximate variant (EXACT=0) or the
// classic two-full-adder exact variant (EXACT=1) with a one-column cin/cout.
module amoa_cprs42_apx
  import amoa_pkg::*;
#(
  parameter bit EXACT = 1'b0
) (
  input  logic x1,
  input  logic x2,
  input  logic x3,
  input  logic x4,
  input  logic cin,
  output logic sum,
  output logic carry,
  output logic cout,
  output logic err
);

  if (EXACT) begin : g_exact
    logic s1;
    // cout depends only on x1..x3, so the chain never ripples past one column
    assign s1    = x1 ^ x2 ^ x3;
    assign cout  = (x1 & x2) | (x1 & x3) | (x2 & x3);
    assign sum   = s1 ^ x4 ^ cin;
    assign carry = (s1 & x4) | (s1 & cin) | (x4 & cin);
    assign err   = 1'b0;
  end else begin : g_apx
    logic unused_cin;
    assign unused_cin = cin;
    // four ones yield sum=0,carry=1 (value 2 instead of 4); err flags that case
    assign sum   = x1 ^ x2 ^ x3 ^ x4;
    assign carry = (x1 & x2) | (x3 & x4) | ((x1 | x2) & (x3 | x4));
    assign err   = x1 & x2 & x3 & x4;
    assign cout  = 1'b0;
  end

endmodule

// File: rtl/amoa_param_pipe.sv
// N-operand adder: 4:2 compressor tree (low APX_COLS columns approximate),
// carry-propagate adder, valid/ready pipeline of PIPE stages, err statistics.
// Define AMOA_ERR_COMP_EN to re-inject err events in the CPA (exact summ).
module amoa_param_pipe
  import amoa_pkg::*;
#(
  parameter int W        = 8,
  parameter int N        = 8,
  parameter int APX_COLS = W,
  parameter int PIPE     = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N*W-1:0]           x,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ow_of(W, N)-1:0]   summ,
  output logic                     err_flag,
  output logic [15:0]              err_cnt,
  input  logic                     err_clr
);

  localparam int OW = ow_of(W, N);
  localparam int L  = clog2(N) - 1;

  // Layer l holds N>>l vectors; each layer also carries the running err weight.
  for (genvar l = 0; l <= L; l++) begin : g_layer
    logic [N-1:0][OW-1:0] lv;
    logic [OW-1:0]        acc;
    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < N; i++) begin : g_op
        assign lv[i] = {{(OW-W){1'b0}}, x[i*W +: W]};
      end
      assign acc = '0;
    end else begin : g_cprs
      localparam int NG = (N >> (l - 1)) / 4;
      logic [NG-1:0][OW-1:0] cw;
      logic [NG-1:0][OW-1:0] eb;
      logic [OW-1:0]         lacc;
      logic                  unused_bits;
      for (genvar g = 0; g < NG; g++) begin : g_grp
        for (genvar c = 0; c < OW; c++) begin : g_col
          logic cin;
          logic co;
          if (c == 0) begin : g_c0
            assign cin = 1'b0;
          end else begin : g_cn
            assign cin = g_col[c-1].co;
          end
          if (c == OW - 1) begin : g_top
            logic unused_co;
            assign unused_co = co;
          end
          amoa_cprs42_apx #(
            .EXACT (c >= APX_COLS)
          ) u_cell (
            .x1    (g_layer[l-1].lv[4*g][c]),
            .x2    (g_layer[l-1].lv[4*g+1][c]),
            .x3    (g_layer[l-1].lv[4*g+2][c]),
            .x4    (g_layer[l-1].lv[4*g+3][c]),
            .cin   (cin),
            .sum   (lv[2*g][c]),
            .carry (cw[g][c]),
            .cout  (co),
            .err   (eb[g][c])
          );
        end
        assign lv[2*g+1] = {cw[g][OW-2:0], 1'b0};
      end
      for (genvar j = 2 * NG; j < N; j++) begin : g_idle
        assign lv[j] = '0;
      end
      // each err event at column c lost 2^(c+1)
      always_comb begin
        lacc = '0;
        for (int g = 0; g < NG; g++) begin
          lacc = lacc + (eb[g] << 1);
        end
      end
      assign acc = g_layer[l-1].acc + lacc;
      assign unused_bits = ^{cw, lv};
    end
  end

  stage_t tree_s;
  stage_t s1;
  logic   out_adv;
  logic   unused_s1;

  // Pack the tree result into the stage payload.
  always_comb begin
    tree_s = '0;
    tree_s.valid          = in_valid;
    tree_s.psum[OW-1:0]   = g_layer[L].lv[0];
    tree_s.pcar[OW-1:0]   = g_layer[L].lv[1];
    tree_s.err[OW-1:0]    = g_layer[L].acc;
  end

  assign out_adv = !out_valid | out_ready;

  if (PIPE == 2) begin : g_tree_reg
    stage_t s1_r;
    // Tree register: loads whenever it is empty or drains into the output stage.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_r <= '0;
      end else if (in_ready) begin
        s1_r <= tree_s;
      end
    end
    assign s1       = s1_r;
    assign in_ready = !s1_r.valid | out_adv;
  end else begin : g_no_tree_reg
    assign s1       = tree_s;
    assign in_ready = out_adv;
  end

  assign unused_s1 = ^s1;

  logic [OW-1:0] cpa_s;
  logic          err_any_s;

  // Final carry-propagate adder, optionally restoring the dropped weight.
  always_comb begin
    cpa_s = s1.psum[OW-1:0] + s1.pcar[OW-1:0];
`ifdef AMOA_ERR_COMP_EN
    cpa_s = cpa_s + s1.err[OW-1:0];
`else
    cpa_s = cpa_s + {OW{1'b0}};
`endif
    err_any_s = |s1.err[OW-1:0];
  end

  // Output register: holds summ/err_flag stable while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      summ      <= '0;
      err_flag  <= 1'b0;
    end else if (out_adv) begin
      out_valid <= s1.valid;
      if (s1.valid) begin
        summ     <= cpa_s;
        err_flag <= err_any_s;
      end
    end
  end

  // Saturating count of delivered err results; clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= 16'd0;
    end else if (err_clr) begin
      err_cnt <= 16'd0;
    end else if (out_valid && out_ready && err_flag && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end

endmodule
